// File: rtl/five_row_ctrl_pkg.sv
// Shared definitions for the five-row window controller: FSM encoding and
// row-buffer / window geometry.
package five_row_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_ROWS = 5;
  localparam int WIN_SIZE = 5;

endpackage

// File: rtl/mod5_ptr.sv
// Modulo-5 row-buffer pointer: synchronous clear has priority over advance,
// and 4 advances back to 0.
module mod5_ptr (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  output logic [2:0] ptr
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= 3'd0;
    end else if (clear) begin
      ptr <= 3'd0;
    end else if (advance) begin
      ptr <= (ptr == 3'd4) ? 3'd0 : ptr + 3'd1;
    end
  end

endmodule

// File: rtl/five_row_ctrl.sv
// Five-row line-buffer controller: tracks pixel position, rotates the row
// buffer write select and flags when a full 5x5 window is available.
module five_row_ctrl
  import five_row_ctrl_pkg::*;
#(
  parameter int WIDTH  = 420,
  parameter int HEIGHT = 315
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sof,
  input  logic                validin,
  output logic [NUM_ROWS-1:0] asel,
  output logic [2:0]          top_idx,
  output logic [10:0]         col,
  output logic [10:0]         row,
  output logic                window_valid,
  output logic                eof,
  output logic                err
);

  localparam logic [10:0] COL_LAST  = 11'(WIDTH - 1);
  localparam logic [10:0] ROW_LAST  = 11'(HEIGHT - 1);
  localparam logic [10:0] FILL_LAST = 11'(WIN_SIZE - 2);
  localparam logic [10:0] WIN_EDGE  = 11'(WIN_SIZE - 1);

  state_t     state, state_nxt;
  logic       active;
  logic       accept;
  logic       col_wrap;
  logic       last_px;
  logic [2:0] ptr;

  // sof always wins over a coincident pixel, so it is removed from accept.
  assign active   = (state == FILL) || (state == STREAM);
  assign accept   = validin && active && !sof;
  assign col_wrap = accept && (col == COL_LAST);
  assign last_px  = col_wrap && (row == ROW_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (sof) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (col_wrap && (row == FILL_LAST)) state_nxt = STREAM;
        STREAM:  if (last_px) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Row saturates on the final wrap so it never exceeds HEIGHT-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col <= 11'd0;
      row <= 11'd0;
    end else if (sof) begin
      col <= 11'd0;
      row <= 11'd0;
    end else if (accept) begin
      col <= col_wrap ? 11'd0 : col + 11'd1;
      if (col_wrap && (row != ROW_LAST)) begin
        row <= row + 11'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      eof <= 1'b0;
      err <= 1'b0;
    end else begin
      eof <= last_px;
      if ((sof && active) || (validin && !sof && !active)) begin
        err <= 1'b1;
      end
    end
  end

  mod5_ptr u_ptr (
    .clock   (clock),
    .reset   (reset),
    .clear   (sof),
    .advance (col_wrap),
    .ptr     (ptr)
  );

  assign asel         = active ? (NUM_ROWS'(1) << ptr) : '0;
  assign top_idx      = (ptr == 3'd4) ? 3'd0 : ptr + 3'd1;
  assign window_valid = validin && (state == STREAM) && (col >= WIN_EDGE);

endmodule

// File: tb/tb_five_row_ctrl.sv
// Directed bench for five_row_ctrl with an 8x6 frame: contiguous and gapped
// streams, mid-frame sof, stray pixels in DONE, async reset and sof+validin.
module tb_five_row_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sof = 1'b0;
  logic        validin = 1'b0;
  logic [4:0]  asel;
  logic [2:0]  top_idx;
  logic [10:0] col;
  logic [10:0] row;
  logic        window_valid;
  logic        eof;
  logic        err;

  int checks = 0;
  int failures = 0;

  five_row_ctrl #(.WIDTH(8), .HEIGHT(6)) dut (
    .clock        (clock),
    .reset        (reset),
    .sof          (sof),
    .validin      (validin),
    .asel         (asel),
    .top_idx      (top_idx),
    .col          (col),
    .row          (row),
    .window_valid (window_valid),
    .eof          (eof),
    .err          (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sof = 1'b0;
    validin = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic start_frame();
    sof = 1'b1;
    validin = 1'b0;
    tick();
    sof = 1'b0;
  endtask

  task automatic feed(input int n);
    validin = 1'b1;
    for (int i = 0; i < n; i++) tick();
    validin = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_col"}, col, 0);
    check({tag, "_row"}, row, 0);
    check({tag, "_asel"}, asel, 0);
    check({tag, "_top"}, top_idx, 1);
    check({tag, "_wv"}, window_valid, 0);
    check({tag, "_eof"}, eof, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Full 8x6 frame; gap inserts an idle cycle before every pixel.
  task automatic run_frame(input bit gap);
    int wv_cnt;
    int eof_cnt;
    logic [4:0] exp_asel;
    wv_cnt = 0;
    eof_cnt = 0;
    start_frame();
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (gap) begin
          validin = 1'b0;
          #1;
          if (eof) eof_cnt++;
          tick();
        end
        validin = 1'b1;
        #1;
        check("px_col", col, c);
        check("px_row", row, r);
        check("px_wv", window_valid, (r >= 4 && c >= 4) ? 1 : 0);
        if (window_valid) wv_cnt++;
        if (eof) eof_cnt++;
        if (c == 0) begin
          exp_asel = 5'b00001 << (r % 5);
          check("row_asel", asel, exp_asel);
          check("row_top", top_idx, ((r % 5) + 1) % 5);
        end
        tick();
      end
    end
    validin = 1'b0;
    #1;
    check("eof_pulse", eof, 1);
    check("done_asel", asel, 0);
    eof_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (eof) eof_cnt++;
    end
    check("wv_count", wv_cnt, 8);
    check("eof_count", eof_cnt, 1);
    check("frame_err", err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state while reset is held low
    #2;
    check_reset_vals("rst");
    tick();
    reset = 1'b1;
    tick();

    // Contiguous frame
    run_frame(1'b0);

    // Gapped frame
    do_reset();
    run_frame(1'b1);

    // sof at pixel (2,3): pixel dropped, counters restart
    do_reset();
    start_frame();
    feed(19);
    sof = 1'b1;
    validin = 1'b1;
    tick();
    sof = 1'b0;
    #1;
    check("resof_col", col, 0);
    check("resof_row", row, 0);
    check("resof_asel", asel, 5'b00001);
    check("resof_err", err, 1);
    tick();
    #1;
    check("resof_next_col", col, 1);
    validin = 1'b0;

    // Stray pixels in DONE
    do_reset();
    start_frame();
    feed(48);
    #1;
    check("done_entry_err", err, 0);
    for (int i = 0; i < 3; i++) begin
      validin = 1'b1;
      tick();
      validin = 1'b0;
      tick();
    end
    check("done_col", col, 0);
    check("done_row", row, 5);
    check("done_asel2", asel, 0);
    check("done_err", err, 1);

    // Async reset at pixel (4,5)
    do_reset();
    start_frame();
    feed(37);
    validin = 1'b1;
    #1;
    check("pre_rst_col", col, 5);
    check("pre_rst_row", row, 4);
    check("pre_rst_wv", window_valid, 1);
    check("pre_rst_asel", asel, 5'b10000);
    reset = 1'b0;
    #1;
    check_reset_vals("async");
    validin = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_asel", asel, 0);

    // sof and validin together in IDLE
    do_reset();
    sof = 1'b1;
    validin = 1'b1;
    tick();
    sof = 1'b0;
    validin = 1'b0;
    #1;
    check("idle_sof_col", col, 0);
    check("idle_sof_asel", asel, 5'b00001);
    validin = 1'b1;
    tick();
    validin = 1'b0;
    #1;
    check("idle_sof_next_col", col, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/five_row_ctrl.md
FIVE_ROW_CTRL -- requirements
Module: five_row_ctrl

Interface
REQ-001 Parameter WIDTH, default 420: pixels per image row; legal values are 210 and 420.
REQ-002 Parameter HEIGHT, default 315: rows per frame; minimum 5, maximum 2047.
REQ-003 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port sof, input, 1 bit: start-of-frame pulse, one cycle long, sampled independently of validin.
REQ-006 Port validin, input, 1 bit: the current cycle carries one accepted pixel.
REQ-007 Port asel, output, 5 bits: one-hot write select for the five row buffers.
REQ-008 Port top_idx, output, 3 bits, range 0-4: index of the buffer holding the oldest row in the window.
REQ-009 Port col, output, 11 bits: column of the current pixel.
REQ-010 Port row, output, 11 bits: row of the current pixel.
REQ-011 Port window_valid, output, 1 bit: the 5x5 window centred at (row-2, col-2) is complete this cycle.
REQ-012 Port eof, output, 1 bit: one-cycle pulse when the last pixel of the frame is accepted.
REQ-013 Port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-014 The FSM SHALL have the states IDLE, FILL, STREAM and DONE.
REQ-015 IDLE or DONE SHALL move to FILL on sof; FILL SHALL move to STREAM on the accepted pixel (3, WIDTH-1); STREAM SHALL move to DONE on the accepted pixel (HEIGHT-1, WIDTH-1).
REQ-016 Entering FILL SHALL clear col, row and the internal pointer ptr to 0.
REQ-017 An accepted pixel is validin=1 in FILL or STREAM; col SHALL increment by 1 for each accepted pixel and wrap from WIDTH-1 to 0.
REQ-018 On that wrap, row SHALL increment and ptr SHALL advance modulo 5 (4 wraps to 0).
REQ-019 asel SHALL be 1<<ptr in FILL and STREAM, and SHALL be 0 in IDLE and DONE.
REQ-020 top_idx SHALL equal (ptr+1) mod 5.
REQ-021 window_valid SHALL be combinational and equal to validin & (state==STREAM) & (col>=4); it has zero latency.
REQ-022 eof SHALL be registered and assert in the cycle after the final pixel is accepted, together with entry to DONE.
REQ-023 validin in IDLE or DONE SHALL be ignored and SHALL set err.
REQ-024 sof in FILL or STREAM SHALL set err and restart FILL, with counters cleared, in the next cycle.
REQ-025 If sof and validin occur in the same cycle, sof SHALL win and the pixel SHALL be dropped.
REQ-026 err SHALL clear only on reset.
REQ-027 Counter comparisons SHALL use WIDTH-1 and HEIGHT-1 at 11 bits; no counter may exceed its bound.

Reset
REQ-028 While reset is asserted (low): state=IDLE, col=0, row=0, ptr=0, asel=0, top_idx=1, window_valid=0, eof=0, err=0.
REQ-029 Assertion of reset mid-frame SHALL abort the frame immediately; the next frame requires a new sof.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (2 bits), the row-buffer count 5 and the window size 5.
REQ-031 The block SHALL instance one sub-module, mod5_ptr, a modulo-5 pointer with an advance enable.
REQ-032 The block SHALL instantiate no memory; it drives the select and enable inputs of the five-row line buffer.

Verification
REQ-033 WIDTH=8, HEIGHT=6, sof followed by 48 contiguous valid pixels:
- asel sequence 00001, 00010, 00100, 01000, 10000, 00001 (one value per row).
- window_valid high on exactly 8 pixels: rows 4-5, cols 4-7.
- eof pulses once; err stays 0.
REQ-034 Same frame with validin toggling every other cycle: counter values and pulse counts identical to REQ-033.
REQ-035 sof issued at pixel (2,3):
- err=1.
- The next accepted pixel is (0,0) with asel=00001.
REQ-036 validin pulsed 3 times in DONE: col and row unchanged, err=1.
REQ-037 reset low at pixel (4,5): all outputs take the REQ-028 values asynchronously.
REQ-038 sof and validin in the same cycle while in IDLE: state goes to FILL and col stays 0.
